karatsuba_mul_162: RTL and testbench
====================================

# karatsuba_mul_162

Fully pipelined 163×163-bit carry-less (GF(2)[x]) polynomial multiplier built from recursive Karatsuba decomposition. It produces the unreduced 325-bit product that feeds the GF(2^163) modular-reduction stage of the ECC datapath. The block accepts one operand pair per clock and returns one product per clock after a fixed latency. Reduction modulo the field polynomial happens downstream, not in this block.

## Interface
- No parameters; widths are fixed at 163 in and 325 out.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  A/B are valid this cycle.
- A  input  163  operand a(x); bit i is the coefficient of x^i.
- B  input  163  operand b(x); same encoding as A.
- out_valid  output  1  out holds a valid product.
- out  output  325  product a(x)·b(x) over GF(2); bit i is the coefficient of x^i.

## Operation
- Arithmetic is carry-less: partial products combine by XOR, not by addition. The result is the polynomial product with no reduction.
- Top-level split at bit 82:
  - A = Ah·x^82 + Al, with Al = A[81:0] and Ah = A[162:82] zero-extended to 82 bits. B splits the same way.
- Compute three sub-products: P0 = Al·Bl, P2 = Ah·Bh, and P1 = (Al^Ah)·(Bl^Bh).
- Combine: out = P2·x^164 ^ (P1^P0^P2)·x^82 ^ P0, truncated to 325 bits.
  - Bits above 324 are always zero by construction.
- Apply the same scheme recursively to the 82-bit sub-multipliers, splitting at 41, then 21.
- Operands of 21 bits or fewer use a schoolbook AND/XOR array.
- The design must be bit-exact against a reference shift-and-XOR multiplier for all inputs.
- No backpressure: every cycle with in_valid=1 yields exactly one out_valid=1 cycle after the latency.
- in_valid propagates through a valid shift chain matched to the data pipeline.
- When out_valid=0, out holds its last value. Consumers must not use out while out_valid=0.

## Timing
- Stage 1: A, B and in_valid are registered on the rising edge of clk.
- Stage 2: the Karatsuba combine result is registered into out, and out_valid is asserted.
- Latency is 2 cycles from an in_valid sample to out_valid. With KARATSUBA_PIPE_EN defined, latency is 3 cycles.
- Throughput is 1 product per cycle. Back-to-back inputs return back-to-back in order.
- Reset values: out = 0, out_valid = 0, and all internal pipeline and valid registers = 0.
- Reset asserted mid-operation: every in-flight operation is discarded, and no out_valid pulse is generated for it.
- After rst_n deasserts, the first in_valid is accepted on the next rising edge.

## Configuration
- KARATSUBA_PIPE_EN defined:
  - An extra register stage captures P0, P1 and P2 of the top-level split before the combine XOR.
  - Latency becomes 3 cycles. Throughput is unchanged.
- KARATSUBA_PIPE_EN undefined:
  - The top-level sub-products and the combine are purely combinational between the stage-1 and output registers.
  - Latency is 2 cycles.
- Results are identical in both builds; only latency differs.

## Test plan
- Reset: hold rst_n=0 while driving in_valid=1 with A=5, B=5 -> out=0 and out_valid=0 throughout. After release, the first product appears exactly at the configured latency.
- Small values, issued back-to-back one per cycle, results expected in order:
  - 5⊗5 -> 17
  - 512⊗1024 -> 524288
  - 10⊗15 -> 102
  - 12⊗13 -> 92
- Boundaries:
  - A = 2^163−1, B = 1 -> out = 2^163−1.
  - A = B = x^162 -> out = x^324 (only bit 324 set).
  - A = 0 with any B -> out = 0.
- Split-boundary carries: A = x^81 + x^82, B = x^81 + x^82 -> out = x^162 + x^164. This checks that the middle term cancels correctly.
- Random: 10,000 random pairs with random in_valid gaps -> every result matches the shift-and-XOR reference model. The out_valid count equals the in_valid count.
- Mid-stream reset: assert rst_n=0 while two operations are in flight -> neither operation produces out_valid, and out reads 0.

Source files
------------

// File: rtl/karatsuba_mul_162_if.sv
// Operand/product bus for the 163x163 carry-less Karatsuba multiplier.
interface karatsuba_mul_162_if;
  logic         in_valid;
  logic [162:0] A;
  logic [162:0] B;
  logic         out_valid;
  logic [324:0] out;

  modport master (output in_valid, A, B, input out_valid, out);
  modport slave  (input in_valid, A, B, output out_valid, out);
endinterface

// File: rtl/karatsuba_mul_162.sv
// Pipelined 163x163 GF(2)[x] multiplier (Karatsuba 82/41/21, schoolbook leaves), unreduced 325-bit product.
// Define KARATSUBA_PIPE_EN to register the top-level sub-products before the combine (latency 3 instead of 2).
module karatsuba_mul_162 (
  input logic                clk,
  input logic                rst_n,
  karatsuba_mul_162_if.slave bus
);

  function automatic logic [40:0] clmul21(input logic [20:0] a, input logic [20:0] b);
    logic [40:0] acc;
    logic [40:0] a_ext;
    acc   = '0;
    a_ext = {20'b0, a};
    for (int i = 0; i < 21; i++) begin
      if (b[i]) acc = acc ^ (a_ext << i);
    end
    return acc;
  endfunction

  // 41-bit operands split at 21; the 20-bit high halves are zero-extended.
  function automatic logic [80:0] clmul41(input logic [40:0] a, input logic [40:0] b);
    logic [20:0] al, ah, bl, bh;
    logic [40:0] p0, p1, p2;
    al = a[20:0];
    ah = {1'b0, a[40:21]};
    bl = b[20:0];
    bh = {1'b0, b[40:21]};
    p0 = clmul21(al, bl);
    p2 = clmul21(ah, bh);
    p1 = clmul21(al ^ ah, bl ^ bh);
    return {40'b0, p0} ^ ({40'b0, p0 ^ p1 ^ p2} << 21) ^ ({40'b0, p2} << 42);
  endfunction

  function automatic logic [162:0] clmul82(input logic [81:0] a, input logic [81:0] b);
    logic [40:0] al, ah, bl, bh;
    logic [80:0] p0, p1, p2;
    al = a[40:0];
    ah = a[81:41];
    bl = b[40:0];
    bh = b[81:41];
    p0 = clmul41(al, bl);
    p2 = clmul41(ah, bh);
    p1 = clmul41(al ^ ah, bl ^ bh);
    return {82'b0, p0} ^ ({82'b0, p0 ^ p1 ^ p2} << 41) ^ ({82'b0, p2} << 82);
  endfunction

  function automatic logic [324:0] combine(input logic [162:0] p0, input logic [162:0] p1,
                                           input logic [162:0] p2);
    return {162'b0, p0} ^ ({162'b0, p0 ^ p1 ^ p2} << 82) ^ ({162'b0, p2} << 164);
  endfunction

  logic [162:0] a_q, b_q;
  logic         v_q;
  logic [81:0]  al, ah, bl, bh;
  logic [162:0] p0, p1, p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= bus.in_valid;
      if (bus.in_valid) begin
        a_q <= bus.A;
        b_q <= bus.B;
      end
    end
  end

  always_comb begin
    al = a_q[81:0];
    ah = {1'b0, a_q[162:82]};
    bl = b_q[81:0];
    bh = {1'b0, b_q[162:82]};
    p0 = clmul82(al, bl);
    p2 = clmul82(ah, bh);
    p1 = clmul82(al ^ ah, bl ^ bh);
  end

`ifdef KARATSUBA_PIPE_EN
  logic [162:0] p0_q, p1_q, p2_q;
  logic         v2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_q          <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      v2_q          <= 1'b0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      v2_q          <= v_q;
      bus.out_valid <= v2_q;
      if (v_q) begin
        p0_q <= p0;
        p1_q <= p1;
        p2_q <= p2;
      end
      if (v2_q) bus.out <= combine(p0_q, p1_q, p2_q);
    end
  end
`else
  // out only updates on valid products so it holds its last value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= v_q;
      if (v_q) bus.out <= combine(p0, p1, p2);
    end
  end
`endif

endmodule

// File: tb/tb_karatsuba_mul_162.sv
// Randomized self-checking bench for karatsuba_mul_162 against a shift-and-XOR reference.
module tb_karatsuba_mul_162;

`ifdef KARATSUBA_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [324:0] prod;
    int           issued;
    string        tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cycle;
  int   n_issued;
  int   n_outs;
  exp_t exp_q[$];
  exp_t mon_e;

  karatsuba_mul_162_if bus ();

  karatsuba_mul_162 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [324:0] got, input logic [324:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [324:0] ref_clmul(input logic [162:0] a, input logic [162:0] b);
    logic [324:0] r;
    r = '0;
    for (int i = 0; i < 163; i++) begin
      if (a[i]) r = r ^ ({162'b0, b} << i);
    end
    return r;
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       t = t & {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      1:       t = ~192'b0;
      default: ;
    endcase
    return t[162:0];
  endfunction

  task automatic applyStimulus(input logic [162:0] a, input logic [162:0] b,
                               input logic [324:0] expected, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    e.prod       = expected;
    e.issued     = cycle;
    e.tag        = tag;
    exp_q.push_back(e);
    n_issued++;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 325'(exp_q.size()), 325'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      n_outs++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 325'd1, 325'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput(mon_e.tag, bus.out, mon_e.prod);
        checkOutput("latency", 325'(cycle - mon_e.issued), 325'(LAT));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [162:0] a, b;
    logic [162:0] ones;
    logic [162:0] top;
    checks = 0;
    failures = 0;
    cycle = 0;
    n_issued = 0;
    n_outs = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.A = 163'd5;
    bus.B = 163'd5;

    repeat (4) begin
      @(negedge clk);
      checkOutput("reset_out", bus.out, 325'd0);
      checkOutput("reset_valid", {324'b0, bus.out_valid}, 325'd0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;

    applyStimulus(163'd5, 163'd5, 325'd17, "p5x5");
    applyStimulus(163'd512, 163'd1024, 325'd524288, "p512x1024");
    applyStimulus(163'd10, 163'd15, 325'd102, "p10x15");
    applyStimulus(163'd12, 163'd13, 325'd92, "p12x13");
    ones = '1;
    top = '0;
    top[162] = 1'b1;
    applyStimulus(ones, 163'd1, {162'b0, ones}, "all_ones_x1");
    applyStimulus(top, top, {1'b1, 324'b0}, "x162_sq");
    applyStimulus(163'd0, rand163(), 325'd0, "zero_a");
    a = '0;
    a[81] = 1'b1;
    a[82] = 1'b1;
    applyStimulus(a, a, (325'd1 << 162) | (325'd1 << 164), "split_carry");
    waitDrain();

    for (int n = 0; n < 10000; n++) begin
      a = rand163();
      b = rand163();
      applyStimulus(a, b, ref_clmul(a, b), "random");
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) idle();
      end
    end
    waitDrain();

    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.A = rand163();
    bus.B = rand163();
    @(posedge clk);
    #1;
    bus.A = rand163();
    bus.B = rand163();
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_out", bus.out, 325'd0);
      checkOutput("midrst_valid", {324'b0, bus.out_valid}, 325'd0);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_rst_valid", {324'b0, bus.out_valid}, 325'd0);
      checkOutput("post_rst_out", bus.out, 325'd0);
    end

    applyStimulus(163'd10, 163'd15, 325'd102, "recover");
    waitDrain();
    checkOutput("valid_count", 325'(n_outs), 325'(n_issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
